i2c_mcp23017_tgt: RTL

I2C target (responder) emulating the register-level behaviour of one MCP23017 16-bit port expander, BANK=0 mapping. It answers the same transactions our I2C initiator sequencer issues to the front-panel expanders: configuration writes, OLAT writes and GPIO reads. It serves as an on-chip stand-in for a missing expander board and as the bus-level model in system benches. It sits on the open-drain SCL/SDA pair and exposes its port pins and output latches as parallel signals.

---
 rtl/mcp23017_pkg.sv | 61 ++++++
 rtl/i2c_bus_sync.sv | 59 +++++
 rtl/i2c_mcp23017_tgt.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp23017_pkg.sv
// Shared constants and types for the MCP23017 (BANK=0) I2C target model.
package mcp23017_pkg;

  localparam int unsigned REG_W   = 8;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned BCNT_W  = 3;

  localparam logic [ADDR_W-1:0] DADDR_DFLT = 7'h20;

  // Register map, shared with the initiator sequencer
  localparam logic [REG_W-1:0] REG_IODIRA = 8'h00;
  localparam logic [REG_W-1:0] REG_IODIRB = 8'h01;
  localparam logic [REG_W-1:0] REG_IPOLA  = 8'h02;
  localparam logic [REG_W-1:0] REG_IPOLB  = 8'h03;
  localparam logic [REG_W-1:0] REG_GPPUA  = 8'h0C;
  localparam logic [REG_W-1:0] REG_GPPUB  = 8'h0D;
  localparam logic [REG_W-1:0] REG_GPIOA  = 8'h12;
  localparam logic [REG_W-1:0] REG_GPIOB  = 8'h13;
  localparam logic [REG_W-1:0] REG_OLATA  = 8'h14;
  localparam logic [REG_W-1:0] REG_OLATB  = 8'h15;
  localparam logic [REG_W-1:0] REG_LAST   = REG_OLATB;

  localparam logic [REG_W-1:0] RST_IODIR  = 8'hFF;
  localparam logic [REG_W-1:0] RST_OTHER  = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_e;

  typedef struct packed {
    logic [REG_W-1:0] iodir_a;
    logic [REG_W-1:0] iodir_b;
    logic [REG_W-1:0] ipol_a;
    logic [REG_W-1:0] ipol_b;
    logic [REG_W-1:0] gppu_a;
    logic [REG_W-1:0] gppu_b;
    logic [REG_W-1:0] olat_a;
    logic [REG_W-1:0] olat_b;
  } regs_t;

  localparam regs_t REGS_RST = '{
    iodir_a: RST_IODIR, iodir_b: RST_IODIR,
    ipol_a:  RST_OTHER, ipol_b:  RST_OTHER,
    gppu_a:  RST_OTHER, gppu_b:  RST_OTHER,
    olat_a:  RST_OTHER, olat_b:  RST_OTHER
  };

  // Pointer auto-increment: anything at or beyond the last register wraps to 0
  function automatic logic [REG_W-1:0] ptr_next(input logic [REG_W-1:0] p);
    return (p >= REG_LAST) ? RST_OTHER : REG_W'(p + 8'h01);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with registered edge, START and STOP pulses.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0],[1] synchronizer stages, [2] previous synchronized sample
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;
  logic       sda_lvl_q, sda_lvl_d;
  logic       scl_rise_q, scl_rise_d;
  logic       scl_fall_q, scl_fall_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;

  always_comb begin
    scl_d      = {scl_q[1:0], scl_i};
    sda_d      = {sda_q[1:0], sda_i};
    sda_lvl_d  = sda_q[1];
    scl_rise_d =  scl_q[1] & ~scl_q[2];
    scl_fall_d = ~scl_q[1] &  scl_q[2];
    start_d    = scl_q[1] & scl_q[2] & ~sda_q[1] &  sda_q[2];
    stop_d     = scl_q[1] & scl_q[2] &  sda_q[1] & ~sda_q[2];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q      <= '1;
      sda_q      <= '1;
      sda_lvl_q  <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      sda_lvl_q  <= sda_lvl_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign sda_lvl_o  = sda_lvl_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_mcp23017_tgt.sv
// I2C target emulating one MCP23017 port expander (BANK=0 register map).
module i2c_mcp23017_tgt
  import mcp23017_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DADDR = DADDR_DFLT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_t,
  input  logic [REG_W-1:0] gpa_i,
  input  logic [REG_W-1:0] gpb_i,
  output logic [REG_W-1:0] olat_a_o,
  output logic [REG_W-1:0] olat_b_o,
  output logic [REG_W-1:0] iodir_a_o,
  output logic [REG_W-1:0] iodir_b_o,
  output logic [REG_W-1:0] gppu_a_o,
  output logic [REG_W-1:0] gppu_b_o,
  output logic             busy_o
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_lvl_o  (sda_lvl),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [REG_W-1:0]    shift_q, shift_d;
  logic [REG_W-1:0]    ptr_q, ptr_d;
  regs_t               regs_q, regs_d;
  logic [2*REG_W-1:0]  gp_q, gp_d;
  logic                sda_t_q, sda_t_d;
  logic                busy_q, busy_d;
  logic                rw_q, rw_d;
  logic                ack_on_q, ack_on_d;

  logic [REG_W-1:0]    byte_in;
  logic                last_bit;
  logic [REG_W-1:0]    rd_val;
  logic [REG_W-1:0]    gpa_s, gpb_s;

  assign byte_in  = {shift_q[REG_W-2:0], sda_lvl};
  assign last_bit = (bit_cnt_q == BCNT_W'(7));
  assign gpa_s    = gp_q[REG_W-1:0];
  assign gpb_s    = gp_q[2*REG_W-1:REG_W];
  assign gp_d     = {gpb_i, gpa_i};

  // Read mux; GPIO merges polarity-adjusted pins (inputs) with the latch (outputs)
  always_comb begin
    rd_val = RST_OTHER;
    case (ptr_q)
      REG_IODIRA: rd_val = regs_q.iodir_a;
      REG_IODIRB: rd_val = regs_q.iodir_b;
      REG_IPOLA:  rd_val = regs_q.ipol_a;
      REG_IPOLB:  rd_val = regs_q.ipol_b;
      REG_GPPUA:  rd_val = regs_q.gppu_a;
      REG_GPPUB:  rd_val = regs_q.gppu_b;
      REG_GPIOA:  rd_val = (regs_q.iodir_a & (gpa_s ^ regs_q.ipol_a))
                         | (~regs_q.iodir_a & regs_q.olat_a);
      REG_GPIOB:  rd_val = (regs_q.iodir_b & (gpb_s ^ regs_q.ipol_b))
                         | (~regs_q.iodir_b & regs_q.olat_b);
      REG_OLATA:  rd_val = regs_q.olat_a;
      REG_OLATB:  rd_val = regs_q.olat_b;
      default:    rd_val = RST_OTHER;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    regs_d    = regs_q;
    sda_t_d   = sda_t_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    ack_on_d  = ack_on_q;

    if (stop_det) begin
      state_d = ST_IDLE;
      sda_t_d = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;

        ST_ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = BCNT_W'(bit_cnt_q + 3'd1);
          if (last_bit) begin
            if (byte_in[7:1] == DADDR && byte_in[7:1] != 7'h00) begin
              state_d  = ST_ADDR_ACK;
              rw_d     = byte_in[0];
              busy_d   = 1'b1;
              ack_on_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end

        // First fall drives ACK, second fall hands the bus to the data phase
        ST_ADDR_ACK: if (scl_fall) begin
          if (!ack_on_q) begin
            sda_t_d  = 1'b0;
            ack_on_d = 1'b1;
          end else if (rw_q) begin
            state_d   = ST_RDATA;
            shift_d   = rd_val;
            sda_t_d   = rd_val[7];
            ptr_d     = ptr_next(ptr_q);
            bit_cnt_d = '0;
          end else begin
            state_d   = ST_PTR;
            sda_t_d   = 1'b1;
            bit_cnt_d = '0;
          end
        end

        ST_PTR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = BCNT_W'(bit_cnt_q + 3'd1);
          if (last_bit) begin
            ptr_d    = byte_in;
            state_d  = ST_PTR_ACK;
            ack_on_d = 1'b0;
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          if (!ack_on_q) begin
            sda_t_d  = 1'b0;
            ack_on_d = 1'b1;
          end else begin
            state_d   = ST_WDATA;
            sda_t_d   = 1'b1;
            bit_cnt_d = '0;
          end
        end

        ST_WDATA: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = BCNT_W'(bit_cnt_q + 3'd1);
          if (last_bit) begin
            case (ptr_q)
              REG_IODIRA:            regs_d.iodir_a = byte_in;
              REG_IODIRB:            regs_d.iodir_b = byte_in;
              REG_IPOLA:             regs_d.ipol_a  = byte_in;
              REG_IPOLB:             regs_d.ipol_b  = byte_in;
              REG_GPPUA:             regs_d.gppu_a  = byte_in;
              REG_GPPUB:             regs_d.gppu_b  = byte_in;
              REG_GPIOA, REG_OLATA:  regs_d.olat_a  = byte_in;
              REG_GPIOB, REG_OLATB:  regs_d.olat_b  = byte_in;
              default: ;
            endcase
            ptr_d    = ptr_next(ptr_q);
            state_d  = ST_WDATA_ACK;
            ack_on_d = 1'b0;
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = BCNT_W'(bit_cnt_q + 3'd1);
            if (last_bit) begin
              state_d  = ST_RDATA_ACK;
              ack_on_d = 1'b0;
            end
          end else if (scl_fall) begin
            shift_d = {shift_q[REG_W-2:0], 1'b0};
            sda_t_d = shift_q[REG_W-2];
          end
        end

        // Release for the initiator's ACK bit; NACK ends the read
        ST_RDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_t_d  = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              state_d   = ST_RDATA;
              shift_d   = rd_val;
              sda_t_d   = rd_val[7];
              ptr_d     = ptr_next(ptr_q);
              bit_cnt_d = '0;
            end
          end else if (scl_rise && ack_on_q && sda_lvl) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= RST_OTHER;
      regs_q    <= REGS_RST;
      gp_q      <= '0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      ack_on_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      regs_q    <= regs_d;
      gp_q      <= gp_d;
      sda_t_q   <= sda_t_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      ack_on_q  <= ack_on_d;
    end
  end

  assign sda_o     = 1'b0;
  assign sda_t     = sda_t_q;
  assign busy_o    = busy_q;
  assign olat_a_o  = regs_q.olat_a;
  assign olat_b_o  = regs_q.olat_b;
  assign iodir_a_o = regs_q.iodir_a;
  assign iodir_b_o = regs_q.iodir_b;
  assign gppu_a_o  = regs_q.gppu_a;
  assign gppu_b_o  = regs_q.gppu_b;

endmodule
